// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcodes, fetch FSM states and immediate-instruction decode
package pipeline_pkg;
  localparam logic [4:0] OP_IADD = 5'b01011;
  localparam logic [4:0] OP_LDD  = 5'b10010;
  localparam logic [4:0] OP_STD  = 5'b10011;
  localparam logic [4:0] OP_LDM  = 5'b10100;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  typedef enum logic [1:0] {BOOT_LO, BOOT_HI, FETCH, IMM} fetch_state_e;
  function automatic logic has_imm(input logic [4:0] op);
    return op inside {OP_LDD, OP_STD, OP_LDM, OP_IADD};
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold (freeze) and clear (redirect)
module if_id_reg import pipeline_pkg::*; #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               clear,
  input  logic               load,
  input  logic [INSTR_W-1:0] nxt_instr,
  input  logic [INSTR_W-1:0] nxt_imm,
  input  logic [PC_W-1:0]    nxt_pc_next,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] imm,
  output logic [PC_W-1:0]    pc_next
);
  // clear wins over hold; an unloaded advance only drops valid
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid   <= 1'b0;
      instr   <= '0;
      imm     <= '0;
      pc_next <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
      instr   <= INSTR_W'(NOP_INSTR);
      imm     <= '0;
      pc_next <= '0;
    end else if (!hold) begin
      valid <= load;
      if (load) begin
        instr   <= nxt_instr;
        imm     <= nxt_imm;
        pc_next <= nxt_pc_next;
      end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/boot FSM, two-word instruction assembly and IF/ID register
module fetch_stage import pipeline_pkg::*; #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               freeze_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_imm,
  output logic [PC_W-1:0]    ifid_pc_next
);
  fetch_state_e state, next_state;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] boot_lo, held;
  logic boot, redir, frz, imm_first, load;
  logic [INSTR_W-1:0] nxt_instr, nxt_imm;
  // boot ignores redirect and freeze so the reset vector is always loaded
  always_comb begin
    boot      = state == BOOT_LO || state == BOOT_HI;
    redir     = redirect_valid && !boot;
    frz       = freeze_pc && !boot && !redir;
    imm_first = state == FETCH && has_imm(imem_rdata[INSTR_W-1 -: 5]);
    load      = (state == FETCH && !imm_first) || state == IMM;
    imem_addr = state == BOOT_LO ? RESET_VEC_ADDR :
                state == BOOT_HI ? RESET_VEC_ADDR + 1'b1 : pc;
    nxt_instr = state == IMM ? held : imem_rdata;
    nxt_imm   = state == IMM ? imem_rdata : '0;
  end
  // next-state: redirect forces FETCH, freeze holds, else advance
  always_comb begin
    next_state = state;
    case (state)
      BOOT_LO: next_state = BOOT_HI;
      BOOT_HI: next_state = FETCH;
      FETCH:   next_state = redir ? FETCH : frz ? FETCH : imm_first ? IMM : FETCH;
      IMM:     next_state = redir ? FETCH : frz ? IMM : FETCH;
      default: next_state = BOOT_LO;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= BOOT_LO;
    else      state <= next_state;
  // PC, boot low half and held first word of an immediate instruction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc      <= '0;
      boot_lo <= '0;
      held    <= '0;
    end else if (state == BOOT_LO) begin
      boot_lo <= imem_rdata;
    end else if (state == BOOT_HI) begin
      pc <= PC_W'({imem_rdata, boot_lo});
    end else if (redir) begin
      pc   <= redirect_pc;
      held <= '0;
    end else if (!frz) begin
      pc <= pc + 1'b1;
      if (imm_first) held <= imem_rdata;
    end
  if_id_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .hold        (frz),
    .clear       (redir),
    .load        (load && !boot),
    .nxt_instr   (nxt_instr),
    .nxt_imm     (nxt_imm),
    .nxt_pc_next (pc + 1'b1),
    .valid       (ifid_valid),
    .instr       (ifid_instr),
    .imm         (ifid_imm),
    .pc_next     (ifid_pc_next)
  );
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline, including the IF/ID pipeline register. It owns the PC and boots from the reset vector stored in instruction memory. It assembles two-word (immediate-carrying) instructions before handing them to decode. It holds in place when the hazard detection unit raises `freeze_pc`, and it redirects and flushes when a later stage signals a taken branch, call, return or interrupt.

## Interface
- `PC_W`, default 32: PC width and instruction-memory address width (word-addressed).
- `INSTR_W`, default 16: instruction word width.
- `RESET_VEC_ADDR`, default 0: imem word holding the boot PC. Boot PC = {imem[addr+1], imem[addr]}, low word first.
- `clk`  in  1: single clock for the whole block.
- `rst`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  PC_W: word address to instruction memory.
- `imem_rdata`  in  INSTR_W: combinational read data for `imem_addr`, valid in the same cycle.
- `freeze_pc`  in  1: load-use stall from hazard detection. Holds the PC, the FSM and IF/ID.
- `redirect_valid`  in  1: taken branch, call, return or interrupt from a later stage.
- `redirect_pc`  in  PC_W: target PC, sampled when `redirect_valid` is high.
- `ifid_valid`  out  1: IF/ID holds a real instruction. When 0 it holds a bubble.
- `ifid_instr`  out  INSTR_W: first instruction word. Opcode is [15:11].
- `ifid_imm`  out  INSTR_W: second word for immediate instructions, otherwise 0.
- `ifid_pc_next`  out  PC_W: address following the complete instruction. Used as the call return address.

## Operation
- FSM states: BOOT_LO, BOOT_HI, FETCH, IMM.
- **BOOT_LO**
  - `imem_addr` = RESET_VEC_ADDR.
  - Latch `imem_rdata` into the boot low half.
  - Go to BOOT_HI.
- **BOOT_HI**
  - `imem_addr` = RESET_VEC_ADDR+1.
  - Load PC = {rdata, low}.
  - Go to FETCH.
  - `ifid_valid` stays 0 in both boot states.
- **FETCH**
  - `imem_addr` = PC.
  - If `has_imm(opcode)`: latch the word into a first-word holding register, PC←PC+1, go to IMM, and do not load IF/ID.
  - Otherwise: IF/ID←{valid=1, instr=word, imm=0, pc_next=PC+1} and PC←PC+1.
- **IMM**
  - `imem_addr` = PC.
  - IF/ID←{valid=1, instr=held word, imm=rdata, pc_next=PC+1}.
  - PC←PC+1, go to FETCH.
- **Priority per cycle, highest first:**
  - Reset.
  - Redirect: PC←`redirect_pc`, state←FETCH, IF/ID←bubble (valid=0, instr=0, imm=0, pc_next=0), any held first word discarded.
  - Freeze: PC, state, holding register and IF/ID all unchanged.
  - Normal advance.
- Redirect and freeze are both ignored in BOOT_LO and BOOT_HI. Boot always completes.
- In FETCH/IMM with IF/ID not loaded that cycle (first half of an immediate instruction), `ifid_valid` is driven to 0 for that cycle. This means a bubble enters decode while the second word is fetched.
- PC arithmetic is modulo 2^PC_W. The all-ones PC wraps to 0 with no flag.

## Timing
- Reset values: state=BOOT_LO, PC=0, `ifid_valid`=0, `ifid_instr`=0, `ifid_imm`=0, `ifid_pc_next`=0, holding register=0.
- `imem_addr` is combinational from state and PC. During reset it equals RESET_VEC_ADDR.
- First valid IF/ID appears on the 3rd rising edge after `rst` deasserts (two boot cycles, then one fetch).
- Latency:
  - Single-word instruction: 1 cycle, PC to IF/ID.
  - Immediate instruction: 2 cycles, with one bubble between it and its predecessor in IF/ID.
- A redirect sampled at edge N: IF/ID is a bubble after N, and the target instruction is in IF/ID after N+1 (single-word).
- Freeze held for k cycles: IF/ID is stable for exactly k edges, then resumes with no lost or duplicated fetch.
- Reset asserted mid-operation (including IMM): all state clears immediately and asynchronously, and boot restarts.

## Structure
- Shared package `pipeline_pkg`:
  - Opcode constants.
  - `has_imm` function, true for LDD 5'b10010, STD 5'b10011, LDM 5'b10100, IADD 5'b01011.
  - FSM state enum.
  - `NOP_INSTR`=0.
- Sub-module `if_id_reg`: registered IF/ID bundle with hold (freeze) and clear (redirect) inputs. The PC and FSM stay in `fetch_stage`.

## Test plan
- **Boot:** imem[0]=0x0040, imem[1]=0x0000. Release reset → `imem_addr` 0, 1, then 0x40. `ifid_valid` first rises after the 3rd edge.
- **Immediate fetch:** imem[0x40]=LDM word, imem[0x41]=0x1234 → one bubble, then IF/ID shows instr=LDM word, imm=0x1234, pc_next=0x42.
- **Freeze:** `freeze_pc` high for 2 cycles after fetching 0x41 → IF/ID unchanged for 2 edges. Next fetch is 0x42, not 0x43.
- **Redirect in IMM:** `redirect_valid`=1, `redirect_pc`=0x80 while in IMM → IF/ID becomes a bubble. Next valid instr comes from 0x80, and the held word is never emitted.
- **Redirect beats freeze:** redirect to 0x90 with `freeze_pc`=1 in the same cycle → PC=0x90 and IF/ID becomes a bubble.
- **Reset and wrap:** PC=0xFFFFFFFF with a single-word instr → pc_next=0. Assert `rst` low while in IMM → outputs zero immediately and the FSM restarts at BOOT_LO.
